// File: rtl/dspctl_pkg.sv
// Shared encodings and fitter-level defaults for the DSP48 MAC-chain sequencer.
package dspctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam int DEF_PIPE_LAT  = 4;
  localparam int DEF_MAX_WORDS = 16;
  localparam int DEF_TO_CYC    = 255;

endpackage

// File: rtl/dsp_valid_delay.sv
// Fixed-depth delay line for {valid, payload}. Payload only advances behind a valid
// bit, so the last stage keeps the most recent result. Reset clears the valid bits only.
module dsp_valid_delay #(
  parameter int DEPTH = 5,
  parameter int W     = 6
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (in_vld) dat_q[0] <= in_dat;
    for (int i = 1; i < DEPTH; i++) begin
      if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/dsp_seq_ctrl.sv
// Event framing, MODECP/FREEZE control and result-valid alignment for one DSP48 MAC chain.
// Optional idle-gap abort is built in when DSPCTL_TIMEOUT_EN is defined.
module dsp_seq_ctrl
  import dspctl_pkg::*;
#(
  parameter int PIPE_LAT  = DEF_PIPE_LAT,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int WC_W      = 5,
  parameter int TO_CYC    = DEF_TO_CYC
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            DV,
  input  logic            EV,
  output logic            MODECP,
  output logic            FREEZE,
  output logic            BUSY,
  output logic            DVout,
  output logic [WC_W-1:0] WCOUNT,
  output logic            ERR,
  output logic            TOUT
);

  localparam int PW = WC_W + 1;

  if (PIPE_LAT < 1 || TO_CYC < 1 || MAX_WORDS >= (1 << WC_W)) begin : g_param_check
    $error("dsp_seq_ctrl: illegal parameter set");
  end

  state_t          state_q, state_d;
  logic [WC_W-1:0] cnt_q, word_cnt;
  logic            ovf_q, word_ovf;
  logic            first, at_max, abort;
  logic            seen_q;
  logic            res_vld;
  logic [PW-1:0]   res_dat;

  // Count including the word being sampled now; saturates, overflow is sticky per event.
  assign first    = (state_q == ST_IDLE);
  assign at_max   = (cnt_q == WC_W'(MAX_WORDS));
  assign word_cnt = first ? WC_W'(1) : (at_max ? cnt_q : cnt_q + 1'b1);
  assign word_ovf = !first && (ovf_q || at_max);

`ifdef DSPCTL_TIMEOUT_EN
  localparam int GAP_W = $clog2(TO_CYC + 1);
  logic [GAP_W-1:0] gap_q;

  assign abort = !DV && (state_q != ST_IDLE) && (gap_q == GAP_W'(TO_CYC - 1));

  always_ff @(posedge CLOCK) begin
    if (RESET || DV || first || abort) gap_q <= '0;
    else                               gap_q <= gap_q + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (DV && !EV) state_d = ST_ACC;
      ST_ACC, ST_HOLD: begin
        if (DV)         state_d = EV ? ST_IDLE : ST_ACC;
        else if (abort) state_d = ST_IDLE;
        else            state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      MODECP  <= 1'b0;
      FREEZE  <= 1'b0;
      BUSY    <= 1'b0;
      TOUT    <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (DV) begin
        cnt_q <= word_cnt;
        ovf_q <= word_ovf;
      end
      MODECP <= DV && first;
      FREEZE <= !DV && !first;
      BUSY   <= (state_d != ST_IDLE);
      TOUT   <= abort;
      seen_q <= seen_q || res_vld;
    end
  end

  dsp_valid_delay #(
    .DEPTH (PIPE_LAT + 1),
    .W     (PW)
  ) u_delay (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .in_vld  (DV && EV),
    .in_dat  ({word_cnt, word_ovf}),
    .out_vld (res_vld),
    .out_dat (res_dat)
  );

  // Result fields read as zero until the first strobe after reset.
  assign DVout  = res_vld;
  assign WCOUNT = (res_vld || seen_q) ? res_dat[PW-1:1] : '0;
  assign ERR    = (res_vld || seen_q) ? res_dat[0] : 1'b0;

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Directed self-checking bench for dsp_seq_ctrl (PIPE_LAT=4, MAX_WORDS=16, TO_CYC=8).
module tb_dsp_seq_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       DV = 1'b0;
  logic       EV = 1'b0;
  logic       MODECP, FREEZE, BUSY, DVout, ERR, TOUT;
  logic [4:0] WCOUNT;

  int n_chk  = 0;
  int n_fail = 0;

  dsp_seq_ctrl #(
    .PIPE_LAT  (4),
    .MAX_WORDS (16),
    .WC_W      (5),
    .TO_CYC    (8)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .DV     (DV),
    .EV     (EV),
    .MODECP (MODECP),
    .FREEZE (FREEZE),
    .BUSY   (BUSY),
    .DVout  (DVout),
    .WCOUNT (WCOUNT),
    .ERR    (ERR),
    .TOUT   (TOUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic cyc(input logic dv, input logic ev);
    @(negedge CLOCK);
    DV = dv;
    EV = ev;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    n_chk++;
    if ({MODECP, FREEZE, BUSY, DVout, WCOUNT, ERR, TOUT} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {MODECP, FREEZE, BUSY, DVout, WCOUNT, ERR, TOUT});
    end
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic test_three_word;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (MODECP !== 1'b1 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL w3_first: MODECP=%b BUSY=%b expected 1 1", MODECP, BUSY);
    end
    cyc(1'b1, 1'b0);
    n_chk++;
    if (MODECP !== 1'b0) begin
      n_fail++; $display("FAIL w3_second_modecp: got %b expected 0", MODECP);
    end
    cyc(1'b1, 1'b1);
    n_chk++;
    if (MODECP !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL w3_last: MODECP=%b BUSY=%b expected 0 0", MODECP, BUSY);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (DVout !== (i == 4)) begin
        n_fail++; $display("FAIL w3_dvout edge+%0d: got %b expected %b", i, DVout, (i == 4));
      end
      if (i == 1) begin
        n_chk++;
        if (WCOUNT !== 5'd0 || FREEZE !== 1'b0) begin
          n_fail++; $display("FAIL w3_pre_strobe: WCOUNT=%0d FREEZE=%b expected 0 0", WCOUNT, FREEZE);
        end
      end
      if (i == 4) begin
        n_chk++;
        if (WCOUNT !== 5'd3 || ERR !== 1'b0) begin
          n_fail++; $display("FAIL w3_result: WCOUNT=%0d ERR=%b expected 3 0", WCOUNT, ERR);
        end
      end
    end
  endtask

  task automatic test_gap;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (MODECP !== 1'b1 || FREEZE !== 1'b0) begin
      n_fail++; $display("FAIL gap_first: MODECP=%b FREEZE=%b expected 1 0", MODECP, FREEZE);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (FREEZE !== 1'b1 || BUSY !== 1'b1) begin
        n_fail++; $display("FAIL gap_freeze%0d: FREEZE=%b BUSY=%b expected 1 1", i, FREEZE, BUSY);
      end
    end
    cyc(1'b1, 1'b1);
    n_chk++;
    if (MODECP !== 1'b0 || FREEZE !== 1'b0) begin
      n_fail++; $display("FAIL gap_resume: MODECP=%b FREEZE=%b expected 0 0", MODECP, FREEZE);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (DVout !== (i == 4)) begin
        n_fail++; $display("FAIL gap_dvout edge+%0d: got %b expected %b", i, DVout, (i == 4));
      end
      if (i == 1) begin
        n_chk++;
        if (WCOUNT !== 5'd3) begin
          n_fail++; $display("FAIL gap_held_count: got %0d expected 3", WCOUNT);
        end
      end
      if (i == 4) begin
        n_chk++;
        if (WCOUNT !== 5'd2 || ERR !== 1'b0) begin
          n_fail++; $display("FAIL gap_result: WCOUNT=%0d ERR=%b expected 2 0", WCOUNT, ERR);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1);
      n_chk++;
      if (MODECP !== 1'b1 || BUSY !== 1'b0) begin
        n_fail++; $display("FAIL b2b_word%0d: MODECP=%b BUSY=%b expected 1 0", k, MODECP, BUSY);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (DVout !== (i >= 2 && i <= 4)) begin
        n_fail++; $display("FAIL b2b_dvout edge+%0d: got %b expected %b", i, DVout, (i >= 2 && i <= 4));
      end
      if (i >= 2 && i <= 4) begin
        n_chk++;
        if (WCOUNT !== 5'd1 || ERR !== 1'b0) begin
          n_fail++; $display("FAIL b2b_result%0d: WCOUNT=%0d ERR=%b expected 1 0", i, WCOUNT, ERR);
        end
      end
    end
  endtask

  task automatic test_overflow;
    // Exactly MAX_WORDS words: saturates without overflow.
    for (int w = 0; w < 15; w++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0);
    n_chk++;
    if (DVout !== 1'b1 || WCOUNT !== 5'd16 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL ovf_exact16: DVout=%b WCOUNT=%0d ERR=%b expected 1 16 0", DVout, WCOUNT, ERR);
    end
    // 18 words: counter saturates, event continues to EV, ERR set.
    for (int w = 0; w < 17; w++) cyc(1'b1, 1'b0);
    n_chk++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL ovf_busy_after17: got %b expected 1", BUSY);
    end
    cyc(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (DVout !== (i == 4)) begin
        n_fail++; $display("FAIL ovf_dvout edge+%0d: got %b expected %b", i, DVout, (i == 4));
      end
      if (i == 4) begin
        n_chk++;
        if (WCOUNT !== 5'd16 || ERR !== 1'b1) begin
          n_fail++; $display("FAIL ovf_result: WCOUNT=%0d ERR=%b expected 16 1", WCOUNT, ERR);
        end
      end
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0);
    n_chk++;
    if (DVout !== 1'b1 || WCOUNT !== 5'd2 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL ovf_next_event: DVout=%b WCOUNT=%0d ERR=%b expected 1 2 0", DVout, WCOUNT, ERR);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    @(negedge CLOCK);
    RESET = 1'b1;
    DV = 1'b1;
    EV = 1'b0;
    @(posedge CLOCK);
    #1;
    n_chk++;
    if ({MODECP, FREEZE, BUSY, DVout, WCOUNT, ERR, TOUT} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b expected all zero",
               {MODECP, FREEZE, BUSY, DVout, WCOUNT, ERR, TOUT});
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    DV = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0);
      if (DVout === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0 || WCOUNT !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_no_dvout: pulses=%0d WCOUNT=%0d expected 0 0", pulses, WCOUNT);
    end
  endtask

`ifdef DSPCTL_TIMEOUT_EN
  task automatic test_timeout;
    int pulses;
    cyc(1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (TOUT !== (i == 8) || BUSY !== (i != 8) || FREEZE !== 1'b1) begin
        n_fail++;
        $display("FAIL to_gap%0d: TOUT=%b BUSY=%b FREEZE=%b expected %b %b 1",
                 i, TOUT, BUSY, FREEZE, (i == 8), (i != 8));
      end
    end
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 1) begin
        n_chk++;
        if (TOUT !== 1'b0 || FREEZE !== 1'b0) begin
          n_fail++; $display("FAIL to_after: TOUT=%b FREEZE=%b expected 0 0", TOUT, FREEZE);
        end
      end
      if (DVout === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL to_no_dvout: pulses=%0d expected 0", pulses);
    end
    // A 7-cycle gap stays open and completes.
    pulses = 0;
    cyc(1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b0);
      if (TOUT === 1'b1 || BUSY !== 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL to_gap7_abort: bad cycles=%0d expected 0", pulses);
    end
    cyc(1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0);
    n_chk++;
    if (DVout !== 1'b1 || WCOUNT !== 5'd2 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL to_gap7_result: DVout=%b WCOUNT=%0d ERR=%b expected 1 2 0", DVout, WCOUNT, ERR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_three_word();
    test_gap();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef DSPCTL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
